// File: rtl/lif_neuron_array_if.sv
// Bus bundle for lif_neuron_array: step/config/counter controls in, spikes and readback out.
interface lif_neuron_array_if #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned W         = 8,
    parameter int unsigned W_IN      = 4,
    parameter int unsigned CNT_W     = 16
);
    localparam int unsigned SEL_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic                      ena;
    logic                      step_valid;
    logic [N_NEURONS*W_IN-1:0] current_in;
    logic                      cfg_we;
    logic [W-1:0]              cfg_threshold;
    logic                      cnt_clr;
    logic [N_NEURONS-1:0]      spike_out;
    logic                      spike_valid;
    logic [SEL_W-1:0]          membrane_sel;
    logic [W-1:0]              membrane_out;
    logic [CNT_W-1:0]          spike_count;

    modport master (
        output ena, step_valid, current_in, cfg_we, cfg_threshold, cnt_clr, membrane_sel,
        input  spike_out, spike_valid, membrane_out, spike_count
    );

    modport slave (
        input  ena, step_valid, current_in, cfg_we, cfg_threshold, cnt_clr, membrane_sel,
        output spike_out, spike_valid, membrane_out, spike_count
    );
endinterface

// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons with refractory period, programmable
// threshold, membrane readback and a saturating global spike counter.
module lif_neuron_array #(
    parameter int unsigned N_NEURONS      = 4,
    parameter int unsigned W              = 8,
    parameter int unsigned W_IN           = 4,
    parameter int unsigned LEAK_SHIFT     = 3,
    parameter int unsigned REFRACT        = 2,
    parameter int unsigned THRESH_DEFAULT = 100,
    parameter int unsigned CNT_W          = 16
) (
    input logic               clk,
    input logic               rst_n,
    lif_neuron_array_if.slave bus
);
    localparam int unsigned SEL_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int unsigned REF_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam int unsigned POP_W = $clog2(N_NEURONS + 1);
    localparam int unsigned ACC_W = CNT_W + POP_W;
    localparam logic [ACC_W-1:0] CNT_MAX = ACC_W'({CNT_W{1'b1}});

    logic [W-1:0]         v_q     [N_NEURONS];
    logic [W-1:0]         v_d     [N_NEURONS];
    logic [REF_W-1:0]     ref_q   [N_NEURONS];
    logic [REF_W-1:0]     ref_d   [N_NEURONS];
    logic [W-1:0]         thresh_q, thresh_d;
    logic [N_NEURONS-1:0] spike_q, spike_d;
    logic                 spike_valid_q, spike_valid_d;
    logic [W-1:0]         membrane_q, membrane_d;
    logic [CNT_W-1:0]     count_q, count_d;

    // Next-state: per-neuron integrate/leak/fire, counter, threshold and readback.
    always_comb begin : next_state_p
        logic             step;
        logic [W-1:0]     leak;
        logic [W:0]       sum;
        logic [W-1:0]     vclamp;
        logic [POP_W-1:0] pop;
        logic [ACC_W-1:0] acc;

        step          = bus.ena & bus.step_valid;
        v_d           = v_q;
        ref_d         = ref_q;
        thresh_d      = thresh_q;
        spike_d       = spike_q;
        spike_valid_d = step;
        membrane_d    = membrane_q;
        count_d       = count_q;
        leak          = '0;
        sum           = '0;
        vclamp        = '0;
        pop           = '0;
        acc           = '0;

        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            leak   = (LEAK_SHIFT == 0) ? '0 : (v_q[i] >> LEAK_SHIFT);
            sum    = (W+1)'(v_q[i]) - (W+1)'(leak) + (W+1)'(bus.current_in[i*W_IN +: W_IN]);
            vclamp = sum[W] ? '1 : sum[W-1:0];
            if (step) begin
                if (ref_q[i] != '0) begin
                    ref_d[i]   = ref_q[i] - REF_W'(1);
                    v_d[i]     = '0;
                    spike_d[i] = 1'b0;
                end else if (vclamp >= thresh_q) begin
                    ref_d[i]   = REF_W'(REFRACT);
                    v_d[i]     = '0;
                    spike_d[i] = 1'b1;
                    pop        = pop + POP_W'(1);
                end else begin
                    v_d[i]     = vclamp;
                    spike_d[i] = 1'b0;
                end
            end
        end

        // A clear coinciding with a step restarts the count from this step's spikes.
        if (step) begin
            acc     = (bus.cnt_clr ? '0 : ACC_W'(count_q)) + ACC_W'(pop);
            count_d = (acc > CNT_MAX) ? '1 : acc[CNT_W-1:0];
        end else if (bus.ena && bus.cnt_clr) begin
            count_d = '0;
        end

        if (bus.ena && bus.cfg_we) begin
            thresh_d = bus.cfg_threshold;
        end

        if (bus.ena) begin
            membrane_d = '0;
            for (int unsigned j = 0; j < N_NEURONS; j++) begin
                if (bus.membrane_sel == SEL_W'(j)) begin
                    membrane_d = v_d[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q           <= '{default: '0};
            ref_q         <= '{default: '0};
            thresh_q      <= W'(THRESH_DEFAULT);
            spike_q       <= '0;
            spike_valid_q <= 1'b0;
            membrane_q    <= '0;
            count_q       <= '0;
        end else begin
            v_q           <= v_d;
            ref_q         <= ref_d;
            thresh_q      <= thresh_d;
            spike_q       <= spike_d;
            spike_valid_q <= spike_valid_d;
            membrane_q    <= membrane_d;
            count_q       <= count_d;
        end
    end

    assign bus.spike_out    = spike_q;
    assign bus.spike_valid  = spike_valid_q;
    assign bus.membrane_out = membrane_q;
    assign bus.spike_count  = count_q;
endmodule

// File: tb/tb_lif_neuron_array.sv
// Bench for lif_neuron_array: two configurations driven by directed and random steps,
// compared each cycle against an arithmetic reference model.
module tb_lif_neuron_array;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lif_neuron_array_if #(.N_NEURONS(4), .W(8), .W_IN(4), .CNT_W(16)) ia ();
    lif_neuron_array_if #(.N_NEURONS(4), .W(8), .W_IN(4), .CNT_W(2))  ib ();

    lif_neuron_array #(.N_NEURONS(4), .W(8), .W_IN(4), .LEAK_SHIFT(3), .REFRACT(2),
                       .THRESH_DEFAULT(100), .CNT_W(16))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));

    lif_neuron_array #(.N_NEURONS(4), .W(8), .W_IN(4), .LEAK_SHIFT(0), .REFRACT(0),
                       .THRESH_DEFAULT(100), .CNT_W(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    int n_tests = 0;
    int n_fail  = 0;

    // Per-instance configuration and reference state.
    int       cfg_ls  [2] = '{3, 0};
    int       cfg_rf  [2] = '{2, 0};
    longint   cfg_cmax[2] = '{65535, 3};
    int       mv  [2][4];
    int       mr  [2][4];
    int       mthr[2];
    logic [3:0] mspk[2];
    int       mval[2];
    int       mmem[2];
    longint   mcnt[2];

    logic [15:0] in_cur[2];
    bit          in_sv [2];
    bit          in_we [2];
    bit          in_clr[2];
    bit          in_en [2];
    int          in_thr[2];
    int          in_sel[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                mv[d][i] = 0;
                mr[d][i] = 0;
            end
            mthr[d] = 100;
            mspk[d] = 4'b0;
            mval[d] = 0;
            mmem[d] = 0;
            mcnt[d] = 0;
        end
    endtask

    task automatic model_cycle(input int d);
        int s;
        int c;
        int pop;
        if (!in_en[d]) begin
            mval[d] = 0;
            return;
        end
        if (in_sv[d]) begin
            pop = 0;
            for (int i = 0; i < 4; i++) begin
                c = int'(in_cur[d][i*4 +: 4]);
                if (mr[d][i] > 0) begin
                    mr[d][i]   = mr[d][i] - 1;
                    mv[d][i]   = 0;
                    mspk[d][i] = 1'b0;
                end else begin
                    s = mv[d][i] - ((cfg_ls[d] == 0) ? 0 : (mv[d][i] >> cfg_ls[d])) + c;
                    if (s > 255) s = 255;
                    if (s >= mthr[d]) begin
                        mspk[d][i] = 1'b1;
                        mv[d][i]   = 0;
                        mr[d][i]   = cfg_rf[d];
                        pop++;
                    end else begin
                        mspk[d][i] = 1'b0;
                        mv[d][i]   = s;
                    end
                end
            end
            mcnt[d] = (in_clr[d] ? 0 : mcnt[d]) + pop;
            if (mcnt[d] > cfg_cmax[d]) mcnt[d] = cfg_cmax[d];
        end else if (in_clr[d]) begin
            mcnt[d] = 0;
        end
        if (in_we[d]) mthr[d] = in_thr[d];
        mval[d] = in_sv[d] ? 1 : 0;
        mmem[d] = mv[d][in_sel[d]];
    endtask

    task automatic apply();
        ia.ena = in_en[0]; ia.step_valid = in_sv[0]; ia.current_in = in_cur[0];
        ia.cfg_we = in_we[0]; ia.cfg_threshold = 8'(in_thr[0]); ia.cnt_clr = in_clr[0];
        ia.membrane_sel = 2'(in_sel[0]);
        ib.ena = in_en[1]; ib.step_valid = in_sv[1]; ib.current_in = in_cur[1];
        ib.cfg_we = in_we[1]; ib.cfg_threshold = 8'(in_thr[1]); ib.cnt_clr = in_clr[1];
        ib.membrane_sel = 2'(in_sel[1]);
    endtask

    task automatic check_all();
        chk("A.spike_out",   64'(ia.spike_out),    64'(mspk[0]));
        chk("A.spike_valid", 64'(ia.spike_valid),  64'(mval[0]));
        chk("A.membrane",    64'(ia.membrane_out), 64'(mmem[0]));
        chk("A.count",       64'(ia.spike_count),  64'(mcnt[0]));
        chk("B.spike_out",   64'(ib.spike_out),    64'(mspk[1]));
        chk("B.spike_valid", 64'(ib.spike_valid),  64'(mval[1]));
        chk("B.membrane",    64'(ib.membrane_out), 64'(mmem[1]));
        chk("B.count",       64'(ib.spike_count),  64'(mcnt[1]));
    endtask

    task automatic tick();
        apply();
        @(posedge clk);
        #1;
        model_cycle(0);
        model_cycle(1);
        check_all();
        for (int d = 0; d < 2; d++) begin
            in_sv[d]  = 1'b0;
            in_we[d]  = 1'b0;
            in_clr[d] = 1'b0;
        end
    endtask

    task automatic step(input int d, input logic [15:0] cur);
        in_sv[d]  = 1'b1;
        in_cur[d] = cur;
        tick();
    endtask

    initial begin
        int seq[12] = '{15, 29, 41, 51, 60, 68, 75, 81, 86, 91, 95, 99};

        model_reset();
        for (int d = 0; d < 2; d++) begin
            in_en[d] = 1'b1; in_sv[d] = 1'b0; in_we[d] = 1'b0; in_clr[d] = 1'b0;
            in_cur[d] = '0; in_thr[d] = 0; in_sel[d] = 0;
        end
        apply();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Integration and leak on neuron 0.
        for (int k = 1; k <= 16; k++) begin
            step(0, 16'h000F);
            if (k <= 12) chk("A.integ_seq", 64'(ia.membrane_out), 64'(seq[k-1]));
            if (k == 13) chk("A.fire_spike", 64'(ia.spike_out), 64'h1);
            if (k >= 13 && k <= 15) chk("A.refract_v", 64'(ia.membrane_out), 64'h0);
            if (k == 16) begin
                chk("A.resume_v", 64'(ia.membrane_out), 64'd15);
                chk("A.one_spike", 64'(ia.spike_count), 64'd1);
            end
        end

        for (int k = 0; k < 40; k++) begin
            in_en[0]  = ($urandom_range(0, 7) != 0);
            in_sv[0]  = ($urandom_range(0, 3) != 0);
            in_cur[0] = 16'($urandom);
            in_clr[0] = ($urandom_range(0, 15) == 0);
            in_we[0]  = ($urandom_range(0, 9) == 0);
            in_thr[0] = int'($urandom_range(20, 140));
            in_sel[0] = int'($urandom_range(0, 3));
            tick();
        end
        in_en[0] = 1'b1;

        // Asynchronous reset in the middle of activity.
        in_we[0] = 1'b1; in_thr[0] = 200; tick();
        repeat (3) step(0, 16'h5555);
        in_sel[0] = 0; tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("A.rst_membrane", 64'(ia.membrane_out), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 16'h0000);
        chk("A.post_rst_valid", 64'(ia.spike_valid), 64'h1);
        chk("A.post_rst_spike", 64'(ia.spike_out), 64'h0);
        tick();
        chk("A.valid_pulse", 64'(ia.spike_valid), 64'h0);

        // Threshold written alongside a step takes effect on the following step.
        step(0, 16'h0008);
        in_we[0] = 1'b1; in_thr[0] = 10;
        step(0, 16'h0003);
        chk("A.old_thresh", 64'(ia.spike_out), 64'h0);
        step(0, 16'h0003);
        chk("A.new_thresh", 64'(ia.spike_out), 64'h1);

        in_en[0] = 1'b0; in_sv[0] = 1'b1; in_we[0] = 1'b1; in_thr[0] = 1;
        in_clr[0] = 1'b1; in_cur[0] = 16'hFFFF;
        tick();
        chk("A.gated_valid", 64'(ia.spike_valid), 64'h0);
        in_en[0] = 1'b1;

        step(0, 16'h0000);
        step(0, 16'h0000);
        in_clr[0] = 1'b1;
        step(0, 16'hFFFF);
        chk("A.clr_step_spike", 64'(ia.spike_out), 64'hF);
        chk("A.clr_step_count", 64'(ia.spike_count), 64'd4);

        // Saturating membrane with no leak.
        in_we[1] = 1'b1; in_thr[1] = 255; tick();
        in_sel[1] = 1;
        for (int k = 1; k <= 19; k++) begin
            step(1, 16'h00E0);
            if (k == 18) chk("B.sat_v", 64'(ib.membrane_out), 64'd252);
            if (k == 19) begin
                chk("B.sat_spike", 64'(ib.spike_out), 64'h2);
                chk("B.sat_count", 64'(ib.spike_count), 64'd1);
            end
        end

        in_we[1] = 1'b1; in_thr[1] = 10; tick();
        for (int k = 0; k < 5; k++) begin
            step(1, 16'h000F);
            chk("B.norefract_spike", 64'(ib.spike_out[0]), 64'h1);
        end
        chk("B.count_sat", 64'(ib.spike_count), 64'd3);

        for (int k = 0; k < 40; k++) begin
            in_en[1]  = ($urandom_range(0, 7) != 0);
            in_sv[1]  = ($urandom_range(0, 3) != 0);
            in_cur[1] = 16'($urandom);
            in_clr[1] = ($urandom_range(0, 7) == 0);
            in_we[1]  = ($urandom_range(0, 5) == 0);
            in_thr[1] = int'($urandom_range(0, 60));
            in_sel[1] = int'($urandom_range(0, 3));
            tick();
        end
        in_en[1] = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
